// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: operand forwarding,
// load-use and branch handling, data-memory wait FSM with timeout, perf counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             load_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            mem_err_nxt;
  logic            mem_stall;
  logic            lw_stall;

  // M-stage result has priority over W-stage result; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rdm, input logic wm,
                                         input logic [4:0] rdw, input logic ww);
    if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                     return 2'b00;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      to_cnt  <= to_cnt_nxt;
      mem_err <= mem_err_nxt;
    end
  end

  // Next-state logic; a timeout abandons the access and releases the pipeline
  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    mem_err_nxt = mem_err;
    case (state)
      IDLE: begin
        if (mem_req_m && !mem_ready) begin
          state_nxt  = WAIT;
          to_cnt_nxt = TO_W'(1);
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end else if (to_cnt == TO_W'(MEM_TIMEOUT)) begin
          mem_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; a memory stall freezes everything and defers branch/load-use
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    mem_stall   = ((state == IDLE) && mem_req_m && !mem_ready) ||
                  ((state == WAIT) && !mem_ready);
    lw_stall    = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    if (!reset) begin
      forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = lw_stall;
        stall_d = lw_stall;
        flush_e = lw_stall | pc_src_e;
        flush_d = pc_src_e;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_f && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_e && (flush_events != {CNT_W{1'b1}}))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       load_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
  logic [3:0] stall_cycles, flush_events;

  typedef struct {
    string      name;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] stl;   // {stall_f, stall_d, stall_e, stall_m}
    logic [2:0] fl;    // {flush_d, flush_e, flush_w}
    logic       err;
    logic [3:0] sc;
    logic [3:0] fe;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .load_e(load_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
    end
  endtask

  // Monitor: every negedge with a pending expectation is a compare point
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk(mon_e.name, "forward_a_e", int'(forward_a_e), int'(mon_e.fa));
      chk(mon_e.name, "forward_b_e", int'(forward_b_e), int'(mon_e.fb));
      chk(mon_e.name, "stall_fdem", int'({stall_f, stall_d, stall_e, stall_m}), int'(mon_e.stl));
      chk(mon_e.name, "flush_dew", int'({flush_d, flush_e, flush_w}), int'(mon_e.fl));
      chk(mon_e.name, "mem_err", int'(mem_err), int'(mon_e.err));
      chk(mon_e.name, "stall_cycles", int'(stall_cycles), int'(mon_e.sc));
      chk(mon_e.name, "flush_events", int'(flush_events), int'(mon_e.fe));
    end
  end

  task automatic clr_in();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    load_e = 0; reg_write_m = 0; reg_write_w = 0;
    pc_src_e = 0; mem_req_m = 0; mem_ready = 0;
  endtask

  // Queue the expectation for the inputs currently applied, then advance a cycle
  task automatic step(input string name, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] stl, input logic [2:0] fl, input logic err,
                      input logic [3:0] sc, input logic [3:0] fe);
    exp_t e;
    e.name = name; e.fa = fa; e.fb = fb; e.stl = stl; e.fl = fl;
    e.err = err; e.sc = sc; e.fe = fe;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clr_in();
    @(posedge clk);
    #1;
    step("rst_idle", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    load_e = 1; rd_e = 7; rs2_d = 7; pc_src_e = 1;
    rd_m = 5; reg_write_m = 1; rs1_e = 5;
    step("rst_forced_low", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);

    // Forwarding
    reset = 1'b0; clr_in();
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; rs2_e = 5;
    step("fwd_m_prio", 2'b10, 2'b10, 4'b0000, 3'b000, 0, 0, 0);
    reg_write_m = 0;
    step("fwd_w", 2'b01, 2'b01, 4'b0000, 3'b000, 0, 0, 0);
    reg_write_m = 1; rd_m = 0; rd_w = 0;
    step("fwd_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    rs1_e = 3; rs2_e = 9; rd_m = 3; rd_w = 9;
    step("fwd_mixed_ab", 2'b10, 2'b01, 4'b0000, 3'b000, 0, 0, 0);
    rd_m = 9; rd_w = 3;
    step("fwd_mixed_ba", 2'b01, 2'b10, 4'b0000, 3'b000, 0, 0, 0);

    // Load-use
    clr_in();
    load_e = 1; rd_e = 7; rs2_d = 7;
    step("lw_rs2", 2'b00, 2'b00, 4'b1100, 3'b010, 0, 0, 0);
    clr_in();
    step("lw_released", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 1);
    load_e = 1;
    step("lw_rd_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 1);
    rd_e = 12; rs1_d = 12;
    step("lw_rs1", 2'b00, 2'b00, 4'b1100, 3'b010, 0, 1, 1);
    load_e = 0;
    step("lw_not_load", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 2, 2);

    // Branch flush
    clr_in();
    pc_src_e = 1;
    step("br_1", 2'b00, 2'b00, 4'b0000, 3'b110, 0, 2, 2);
    step("br_2", 2'b00, 2'b00, 4'b0000, 3'b110, 0, 2, 3);
    load_e = 1; rd_e = 7; rs2_d = 7;
    step("br_and_lw", 2'b00, 2'b00, 4'b1100, 3'b110, 0, 2, 4);
    clr_in();
    step("br_done", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 3, 5);

    // Three-cycle memory wait with a branch pending throughout
    mem_req_m = 1; mem_ready = 0; pc_src_e = 1;
    step("mw_idle_miss", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 3, 5);
    step("mw_wait_1", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 4, 5);
    step("mw_wait_2", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 5, 5);
    mem_ready = 1;
    step("mw_ready", 2'b00, 2'b00, 4'b0000, 3'b110, 0, 6, 5);
    clr_in();
    step("mw_after", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 6, 6);

    // Zero-wait access and stray ready
    mem_req_m = 1; mem_ready = 1;
    step("zero_wait", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 6, 6);
    mem_req_m = 0;
    step("stray_ready", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 6, 6);

    // Timeout after four WAIT cycles
    clr_in();
    mem_req_m = 1;
    step("to_idle_miss", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 6, 6);
    step("to_wait_1", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 7, 6);
    step("to_wait_2", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 8, 6);
    step("to_wait_3", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 9, 6);
    step("to_wait_4", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 10, 6);
    mem_req_m = 0;
    step("to_err_set", 2'b00, 2'b00, 4'b0000, 3'b000, 1, 11, 6);
    step("to_err_sticky", 2'b00, 2'b00, 4'b0000, 3'b000, 1, 11, 6);

    // Asynchronous reset mid-WAIT
    mem_req_m = 1;
    step("rw_enter", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 11, 6);
    reset = 1'b1;
    step("rw_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    reset = 1'b0; mem_req_m = 0;
    step("rw_idle", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);

    // Counter saturation with a 4-bit counter
    load_e = 1; rd_e = 7; rs1_d = 7;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_%0d", i), 2'b00, 2'b00, 4'b1100, 3'b010, 0,
           4'((i > 15) ? 15 : i), 4'((i > 15) ? 15 : i));
    end
    clr_in();
    step("sat_hold", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 15, 15);

    @(negedge clk);
    #1;
    chk("drain", "queue_size", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
